// File: rtl/alu_iter_muldiv_ctrl.sv
// Iterative MUL/DIVU/REMU sequencer driving the shared EX-stage ALU.
// One add or subtract per cycle for 32 cycles, then a one-cycle DONE.
module alu_iter_muldiv_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        Start_i,
  input  logic [1:0]  Op_i,
  input  logic [31:0] OperandA_i,
  input  logic [31:0] OperandB_i,
  input  logic        Kill_i,
  output logic [31:0] AluA_o,
  output logic [31:0] AluB_o,
  output logic [3:0]  AluCtrl_o,
  input  logic [31:0] AluResult_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [31:0] Result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_RSV  = 2'b11;
  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SUB = 4'b0001;

  state_e      state_q;
  logic [1:0]  op_q;
  // acc_q is the product accumulator for MUL and the partial remainder
  // for divides; dvd_q is the multiplier for MUL and dividend/quotient.
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] dvd_q;
  logic [31:0] div_q;
  logic [4:0]  cnt_q;
  logic [31:0] res_q;

  logic        run;
  logic        is_mul;
  logic [31:0] sh;
  logic        top;
  logic        ge;
  logic [31:0] acc_d;
  logic [31:0] dvd_d;
  logic [31:0] mcand_d;
  logic [31:0] res_d;

  assign run    = (state_q == S_RUN);
  assign is_mul = (op_q == OP_MUL);
  assign sh     = {acc_q[30:0], dvd_q[31]};
  assign top    = acc_q[31];
  assign ge     = top | (sh >= div_q);

  // ALU operand steering and next datapath values for one iteration
  always_comb begin
    AluA_o    = '0;
    AluB_o    = '0;
    AluCtrl_o = CTRL_ADD;
    acc_d     = acc_q;
    dvd_d     = dvd_q;
    mcand_d   = mcand_q;
    if (is_mul) begin
      if (run) begin
        AluA_o = acc_q;
        AluB_o = mcand_q;
      end
      if (dvd_q[0]) acc_d = AluResult_i;
      mcand_d = {mcand_q[30:0], 1'b0};
      dvd_d   = {1'b0, dvd_q[31:1]};
    end else begin
      if (run) begin
        AluA_o    = sh;
        AluB_o    = div_q;
        AluCtrl_o = CTRL_SUB;
      end
      acc_d = ge ? AluResult_i : sh;
      dvd_d = {dvd_q[30:0], ge};
    end
  end

  // Result selection on the final iteration
  always_comb begin
    res_d = acc_d;
    unique case (1'b1)
      is_mul:             res_d = acc_d;
      (op_q == OP_DIVU):  res_d = dvd_d;
      default:            res_d = acc_d;
    endcase
  end

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start_i && (Op_i != OP_RSV) && !Kill_i) begin
            state_q <= S_RUN;
            op_q    <= Op_i;
            cnt_q   <= 5'd31;
            acc_q   <= '0;
            if (Op_i == OP_MUL) begin
              mcand_q <= OperandA_i;
              dvd_q   <= OperandB_i;
            end else begin
              dvd_q <= OperandA_i;
              div_q <= OperandB_i;
            end
          end
        end
        S_RUN: begin
          if (Kill_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= acc_d;
            dvd_q   <= dvd_d;
            mcand_q <= mcand_d;
            if (cnt_q == 5'd0) begin
              state_q <= S_DONE;
              res_q   <= res_d;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy_o   = (state_q != S_IDLE);
  assign Done_o   = (state_q == S_DONE);
  assign Result_o = res_q;

endmodule

// File: tb/tb_alu_iter_muldiv_ctrl.sv
// Directed bench for alu_iter_muldiv_ctrl with a behavioural ALU.
// Cycle n is the interval after the nth edge following Start acceptance.
module tb_alu_iter_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        kill;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_res;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_fail;

  alu_iter_muldiv_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .Start_i     (start),
    .Op_i        (op),
    .OperandA_i  (opa),
    .OperandB_i  (opb),
    .Kill_i      (kill),
    .AluA_o      (alu_a),
    .AluB_o      (alu_b),
    .AluCtrl_o   (alu_ctrl),
    .AluResult_i (alu_res),
    .Busy_o      (busy),
    .Done_o      (done),
    .Result_o    (result)
  );

  assign alu_res = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle and checks the full 34-cycle profile.
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int busy_cnt;
    int done_cyc;
    int done_cnt;
    int ctrl_bad;
    logic [3:0] ectl;
    ectl = (o == 2'b00) ? 4'b0000 : 4'b0001;
    busy_cnt = 0;
    done_cyc = -1;
    done_cnt = 0;
    ctrl_bad = 0;
    start = 1'b1; op = o; opa = a; opb = b;
    step();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c <= 32 && alu_ctrl !== ectl) ctrl_bad++;
      if (c < 33) step();
    end
    n_chk++;
    if (busy_cnt !== 33) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want 33", nm, busy_cnt);
    end
    n_chk++;
    if (done_cnt !== 1 || done_cyc !== 33) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %0d pulses last at %0d want 1 at 33",
               nm, done_cnt, done_cyc);
    end
    n_chk++;
    if (ctrl_bad !== 0) begin
      n_fail++;
      $display("FAIL %s alu_ctrl: %0d bad cycles want 0", nm, ctrl_bad);
    end
    n_chk++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", nm, result, exp);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0 || alu_ctrl !== 4'd0 || result !== exp) begin
      n_fail++;
      $display("FAIL %s idle34: busy=%b done=%b a=%h b=%h ctl=%h res=%h want 0 0 0 0 0 %h",
               nm, busy, done, alu_a, alu_b, alu_ctrl, result, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    opa = '0; opb = '0; kill = 1'b0;
    #12;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b res=%h a=%h b=%h ctl=%h want all 0",
               busy, done, result, alu_a, alu_b, alu_ctrl);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42);
    run_op("mul_ffxff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_op("mul_80x2", 2'b00, 32'h8000_0000, 32'd2, 32'h0);
  endtask

  task automatic test_div();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2);
    run_op("divu_top", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
    run_op("remu_top", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
  endtask

  task automatic test_div_zero();
    run_op("divu_z", 2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_z", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678);
  endtask

  task automatic test_kill();
    int dn;
    run_op("kill_pre", 2'b00, 32'd7, 32'd6, 32'd42);
    dn = 0;
    start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) dn++;
      step();
    end
    if (done) dn++;
    kill = 1'b1;
    step();
    kill = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || dn !== 0) begin
      n_fail++;
      $display("FAIL kill_idle: busy=%b done=%b pulses=%0d want 0 0 0",
               busy, done, dn);
    end
    n_chk++;
    if (result !== 32'd42) begin
      n_fail++;
      $display("FAIL kill_result: got %h want %h", result, 32'd42);
    end
    run_op("kill_restart", 2'b01, 32'd100, 32'd7, 32'd14);
  endtask

  task automatic test_ignore();
    int dn;
    start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd5;
    step();
    start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 33; c++) begin
      start = (c == 5 || c == 33);
      op = 2'b01; opa = 32'd1000; opb = 32'd3;
      if (done) dn = c;
      if (c < 33) step();
    end
    n_chk++;
    if (dn !== 33 || result !== 32'd15) begin
      n_fail++;
      $display("FAIL busy_start: done_at=%0d res=%h want 33 %h",
               dn, result, 32'd15);
    end
    step();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b want 0", busy);
    end
    start = 1'b1; op = 2'b11;
    step();
    start = 1'b0; op = 2'b00;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL op11_start: busy=%b want 0", busy);
    end
    start = 1'b1; kill = 1'b1; op = 2'b00;
    step();
    start = 1'b0; kill = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_kill: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    start = 1'b1; op = 2'b00; opa = 32'd11; opb = 32'd13;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b res=%h a=%h b=%h ctl=%h want all 0",
               busy, done, result, alu_a, alu_b, alu_ctrl);
    end
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) dn++;
      step();
    end
    n_chk++;
    if (dn !== 0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_quiet: activity=%0d res=%h want 0 0", dn, result);
    end
    run_op("post_reset", 2'b00, 32'd11, 32'd13, 32'd143);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_kill();
    test_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
